// File: rtl/am_pkg.sv
// Shared constants and types for the activation-memory bank and its router.
package am_pkg;

  localparam int AM_P     = 64;
  localparam int AM_W     = 8;
  localparam int AM_DEPTH = 8;
  localparam int AM_AW    = (AM_DEPTH > 1) ? $clog2(AM_DEPTH) : 1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/am_bank_if.sv
// Two-port bank access bus between the AM access router (master) and one bank (slave).
interface am_bank_if import am_pkg::*; #(
   parameter int P     = AM_P,
   parameter int W     = AM_W,
   parameter int DEPTH = AM_DEPTH
);
   localparam int N  = P * W;
   localparam int NB = N / 8;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] addr0;
   logic          cs0;
   logic          rw0;
   logic [N-1:0]  wdata0;
   logic [NB-1:0] byteenable0;
   logic [P-1:0]  bank_cs0;
   logic [N-1:0]  rdata0;

   logic [AW-1:0] addr1;
   logic          cs1;
   logic          rw1;
   logic [N-1:0]  wdata1;
   logic [NB-1:0] byteenable1;
   logic [P-1:0]  bank_cs1;
   logic [N-1:0]  rdata1;

   modport master (
      output addr0, cs0, rw0, wdata0, byteenable0, bank_cs0,
      output addr1, cs1, rw1, wdata1, byteenable1, bank_cs1,
      input  rdata0, rdata1
   );

   modport slave (
      input  addr0, cs0, rw0, wdata0, byteenable0, bank_cs0,
      input  addr1, cs1, rw1, wdata1, byteenable1, bank_cs1,
      output rdata0, rdata1
   );
endinterface

// File: rtl/am_bank_bitmask.sv
// Expands per-lane selects and per-byte enables into per-bit lane and write masks.
module am_bank_bitmask #(
   parameter int P = 64,
   parameter int W = 8
) (
   input  logic [P*W/8-1:0] byteenable,
   input  logic [P-1:0]     bank_cs,
   output logic [P*W-1:0]   lane_bits,
   output logic [P*W-1:0]   write_bits
);
   // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
   always_comb begin
      lane_bits  = '0;
      write_bits = '0;
      for (int j = 0; j < P * W; j++) begin
         lane_bits[j]  = bank_cs[j / W];
         write_bits[j] = bank_cs[j / W] & byteenable[j / 8];
      end
   end
endmodule

// File: rtl/am_bank.sv
// Dual-port lane-masked activation-memory bank: flop storage, write-through reads,
// port-0-wins collisions, registered read data and a self-timed clear sequencer.
module am_bank import am_pkg::*; #(
   parameter int P     = AM_P,
   parameter int W     = AM_W,
   parameter int DEPTH = AM_DEPTH
) (
   input  logic     clk,
   input  logic     rst,
   am_bank_if.slave bus,
   input  logic     clr_start,
   output logic     clr_busy,
   output logic     clr_done
);
   localparam int N  = P * W;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

   typedef logic [N-1:0] entry_t;

   entry_t        mem      [DEPTH];
   entry_t        mem_next [DEPTH];
   entry_t        lbits0, lbits1, wbits0, wbits1;
   entry_t        rd0_val, rd1_val, rdata0_q, rdata1_q;
   logic          wr0_en, wr1_en, rd0_en, rd1_en;
   clr_state_e    state, state_next;
   logic [AW-1:0] cnt, cnt_next;
   logic          done_next;

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_EXT;
   endfunction

   am_bank_bitmask #(.P(P), .W(W)) u_mask0 (
      .byteenable (bus.byteenable0),
      .bank_cs    (bus.bank_cs0),
      .lane_bits  (lbits0),
      .write_bits (wbits0)
   );

   am_bank_bitmask #(.P(P), .W(W)) u_mask1 (
      .byteenable (bus.byteenable1),
      .bank_cs    (bus.bank_cs1),
      .lane_bits  (lbits1),
      .write_bits (wbits1)
   );

   assign clr_busy = (state == CLEAR);
   assign wr0_en   = bus.cs0 && (bus.rw0 == RW_WRITE) && !clr_busy;
   assign wr1_en   = bus.cs1 && (bus.rw1 == RW_WRITE) && !clr_busy;
   assign rd0_en   = bus.cs0 && (bus.rw0 == RW_READ)  && !clr_busy;
   assign rd1_en   = bus.cs1 && (bus.rw1 == RW_READ)  && !clr_busy;

   // Port 1 is merged first so port 0 overrides it on overlapping enabled bits.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_next[i] = mem[i];
         if (clr_busy) begin
            if (cnt == AW'(i)) mem_next[i] = '0;
         end else begin
            if (wr1_en && bus.addr1 == AW'(i))
               mem_next[i] = (mem_next[i] & ~wbits1) | (bus.wdata1 & wbits1);
            if (wr0_en && bus.addr0 == AW'(i))
               mem_next[i] = (mem_next[i] & ~wbits0) | (bus.wdata0 & wbits0);
         end
      end
   end

   // Reads look at the post-write entry, giving write-through for same-address accesses.
   assign rd0_val = in_range(bus.addr0) ? (mem_next[bus.addr0] & lbits0) : '0;
   assign rd1_val = in_range(bus.addr1) ? (mem_next[bus.addr1] & lbits1) : '0;

   // NOTE: storage is reset along with the control state so a reset bank always reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         for (int i = 0; i < DEPTH; i++) mem[i] <= mem_next[i];
         if (rd0_en) rdata0_q <= rd0_val;
         if (rd1_en) rdata1_q <= rd1_val;
      end
   end

   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         clr_done <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = '0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (clr_start) state_next = CLEAR;
         end
         CLEAR: begin
            cnt_next = cnt + AW'(1);
            if (cnt == LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: doc/am_bank.md
Name: am_bank

Overview:
- Dual-port, lane-masked activation-memory bank.
- Directly downstream of the AM access router: each router bank interface (amN_*0 / amN_*1) drives one am_bank instance, and its rdata0/rdata1 feed back to the router's registered read-select muxes.
- Flop-based storage of DEPTH entries, each P lanes of W bits.
- 1-cycle registered read latency, per-lane/per-byte write masking, deterministic port collision rules.
- Self-timed clear sequencer that zeroes the whole bank.

Parameters:
- P, 64, number of lanes per entry.
- W, 8, bits per lane; P*W must be a multiple of 8.
- DEPTH, 8, entries per bank; address width AW = clog2(DEPTH) = 3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- addr0  in  AW  port-0 entry address.
- cs0  in  1  port-0 access enable, active-high.
- rw0  in  1  port-0 direction: 0 = read, 1 = write.
- wdata0  in  P*W  port-0 write data.
- byteenable0  in  P*W/8  port-0 byte write enables, active-high.
- bank_cs0  in  P  port-0 lane selects, active-high.
- rdata0  out  P*W  port-0 registered read data.
- addr1, cs1, rw1, wdata1, byteenable1, bank_cs1, rdata1: same widths and meanings as port 0, for port 1.
- clr_start  in  1  pulse that starts a bank clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (asynchronous, rst=1):
  - All storage entries go to 0.
  - rdata0 = rdata1 = 0; clr_busy = 0; clr_done = 0.
  - Clear counter goes to 0 and the FSM goes to IDLE.
- Write enable, port p, bit j of the entry:
  - Asserted when cs_p & rw_p & byteenable_p[j/8] & bank_cs_p[j/W] & !clr_busy.
  - The storage bit updates at the rising edge.
- Read, port p (cs_p=1, rw_p=0, clr_busy=0):
  - At the rising edge, rdata_p lane k <= bank_cs_p[k] ? entry[addr_p] lane k : 0.
  - Data is visible in the next cycle, matching the router's 1-cycle registered select.
- rdata_p holds its last value in any cycle without a read on that port, including writes and clr_busy cycles.
- Read-during-write to the same address in the same cycle (either port): write-through. Bits written this cycle return the new data; all other bits return the stored data.
- Both ports write the same address with overlapping enabled bits: port 0 wins on the overlap. Non-overlapping bits from both ports are written.
- Both ports read the same address: both get identical data.
- An address >= DEPTH (only possible if DEPTH is not a power of 2): the write is dropped and the read returns 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start. clr_busy=1 from the next cycle; the counter starts at 0.
  - In CLEAR, each cycle: entry[counter] <= 0, then counter increments.
  - After the counter == DEPTH-1 entry is cleared: -> IDLE, clr_busy=0, clr_done=1 for exactly one cycle.
  - clr_start at cycle t gives clr_busy high for cycles t+1..t+DEPTH and clr_done at t+DEPTH+1.
  - clr_start while in CLEAR is ignored. A clr_start in the same cycle as clr_done restarts the clear.
  - Port accesses during clr_busy are ignored. The upstream router/core is responsible for not issuing them.
  - Asserting rst mid-clear aborts the clear; state goes to IDLE with all storage zero.
- No combinational path from inputs to rdata*.

Decomposition:
- Shared package am_pkg:
  - Constants AM_P, AM_W, AM_DEPTH, AM_AW.
  - Clear FSM state typedef (IDLE, CLEAR).
  - Constants RW_READ=0 and RW_WRITE=1, shared with the router.
- One sub-module, am_bank_bitmask: combinational; expands byteenable and bank_cs into a P*W bit-enable vector. Instantiated once per port.
- The top level holds the storage, the collision/bypass logic, the read registers and the clear FSM.

Test Plan:
- Basic write/read: port 0 writes addr 3 with wdata = lane k value k+1, all enables set; next cycle port 1 reads addr 3 with bank_cs1 all ones. Required: rdata1 = {64,...,2,1} one cycle after the read.
- Lane masking: entry 5 preloaded with all 0xFF; port 0 writes 0x00 with bank_cs0 = 0x00000000_0000FFFF. Then read with bank_cs = 0xFFFF0000_00000000. Required: lanes 0-15 of entry 5 = 0x00 and the rest 0xFF; rdata lanes 48-63 = 0xFF and lanes 0-47 = 0.
- Collision: same cycle, port 0 writes 0xAA and port 1 writes 0x55 to addr 2 with full masks. Required: a later read returns all 0xAA. Then port 0 writes 0x11 to addr 6 while port 1 reads addr 6. Required: rdata1 = all 0x11 next cycle.
- Clear: fill all 8 entries with nonzero data; pulse clr_start at cycle t. Required: clr_busy high for t+1..t+8, clr_done pulses at t+9, all reads return 0 afterwards. A port-0 write issued at t+4 has no effect.
- Reset mid-clear: assert rst at t+3 of a clear. Required: immediate clr_busy=0 and rdata0=rdata1=0; after release, all entries read 0 and no clr_done pulse is produced.
- Hold: port 0 reads addr 1 (value X), then idles for 3 cycles. Required: rdata0 stays X; a write to addr 1 on port 1 during the idle cycles does not change rdata0.
